bin_counter_display: RTL and testbench

BIN_COUNTER_DISPLAY -- requirements
Module: bin_counter_display

---
 rtl/bin_counter_display_pkg.sv | 11 +
 rtl/bin_counter_display_if.sv | 16 +
 rtl/bin_counter_display_seg7_decoder.sv | 8 +
 rtl/bin_counter_display.sv | 46 ++++
 tb/tb_bin_counter_display.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/bin_counter_display_pkg.sv
// counter_display_pkg: segment type, blank glyph and active-low hex glyph table
package counter_display_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/bin_counter_display_if.sv
// bin_counter_display_if: control, count and segment signals of the counter display
interface bin_counter_display_if import counter_display_pkg::*; #(
  parameter int WIDTH = 6,
  parameter int NDIG = 6
);
  logic en;
  logic up_down;
  logic load;
  logic hex_mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic tc;
  seg7_t [NDIG-1:0] seg;
  modport master (output en, up_down, load, hex_mode, load_val, input q, tc, seg);
  modport slave (input en, up_down, load, hex_mode, load_val, output q, tc, seg);
endinterface

// File: rtl/bin_counter_display_seg7_decoder.sv
// seg7_decoder: 4-bit value to active-low seven-segment glyph, or blank
module seg7_decoder import counter_display_pkg::*; (
  input logic [3:0] val,
  input logic blank,
  output seg7_t glyph
);
  assign glyph = blank ? SEG_BLANK : HEX_GLYPH[val];
endmodule

// File: rtl/bin_counter_display.sv
// bin_counter_display: prescaled up/down counter with registered binary/hex seven-segment display
module bin_counter_display import counter_display_pkg::*; #(
  parameter int WIDTH = 6,
  parameter int NDIG = 6,
  parameter int DIV = 50_000_000
) (
  input logic clk,
  input logic reset,
  bin_counter_display_if.slave bus
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HD = (WIDTH + 3) / 4;
  localparam int QW = 4 * NDIG > WIDTH ? 4 * NDIG : WIDTH;
  logic [PW-1:0] pre;
  logic tick, step, wrap;
  logic [QW-1:0] qz;
  seg7_t [NDIG-1:0] gls;
  always_comb begin
    tick = pre == PW'(DIV - 1);
    step = tick & bus.en & ~bus.load;
    wrap = bus.up_down ? &bus.q : ~|bus.q;
    qz = QW'(bus.q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre <= '0;
      bus.q <= '0;
      bus.tc <= 1'b0;
      bus.seg <= {NDIG{SEG_BLANK}};
    end else begin
      pre <= (bus.load | tick) ? '0 : pre + 1'b1;
      bus.q <= bus.load ? bus.load_val : step ? (bus.up_down ? bus.q + 1'b1 : bus.q - 1'b1) : bus.q;
      bus.tc <= step & wrap;
      bus.seg <= gls;
    end
  // binary mode shows one bit per digit through the same decoder as 4'b000x
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic [3:0] v;
    logic b;
    always_comb begin
      v = bus.hex_mode ? qz[4*i+:4] : {3'b000, qz[i]};
      b = bus.hex_mode ? (i >= HD) : (i >= WIDTH);
    end
    seg7_decoder u_dec (.val(v), .blank(b), .glyph(gls[i]));
  end
endmodule

// File: tb/tb_bin_counter_display.sv
// tb_bin_counter_display: directed stimulus with behavioural model and literal checks
module tb_bin_counter_display;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  bin_counter_display_if #(.WIDTH(6), .NDIG(6)) a_if ();
  bin_counter_display_if #(.WIDTH(6), .NDIG(6)) b_if ();
  bin_counter_display_if #(.WIDTH(8), .NDIG(6)) c_if ();
  bin_counter_display #(.WIDTH(6), .NDIG(6), .DIV(4)) u_a (.clk(clk), .reset(rst), .bus(a_if));
  bin_counter_display #(.WIDTH(6), .NDIG(6), .DIV(1)) u_b (.clk(clk), .reset(rst), .bus(b_if));
  bin_counter_display #(.WIDTH(8), .NDIG(6), .DIV(3)) u_c (.clk(clk), .reset(rst), .bus(c_if));

  logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [41:0] exp_seg(int qv, logic hm);
    logic [41:0] r;
    for (int i = 0; i < 6; i++)
      r[7*i+:7] = hm ? (i < 2 ? gl[(qv >> (4*i)) & 15] : 7'h7f)
                     : (((qv >> i) & 1) == 1 ? 7'b1111001 : 7'b1000000);
    return r;
  endfunction

  // model of instance a: WIDTH=6, DIV=4, count tracked as integer modulo 64
  int mq, mp;
  logic mtc;
  logic [41:0] mseg;
  always @(posedge clk or posedge rst)
    if (rst) begin
      mq = 0; mp = 0; mtc = 0; mseg = {6{7'h7f}};
    end else begin
      mseg = exp_seg(mq, a_if.hex_mode);
      mtc = 0;
      if (a_if.load) begin
        mq = int'(a_if.load_val); mp = 0;
      end else if (mp == 3) begin
        mp = 0;
        if (a_if.en) begin
          if (a_if.up_down) begin mtc = (mq == 63); mq = (mq + 1) % 64; end
          else begin mtc = (mq == 0); mq = (mq + 63) % 64; end
        end
      end else mp = mp + 1;
    end

  always @(negedge clk) begin
    chk("model_q", 64'(a_if.q), 64'(mq));
    chk("model_tc", 64'(a_if.tc), 64'(mtc));
    chk("model_seg", 64'(a_if.seg), 64'(mseg));
  end

  initial begin
    {a_if.en, a_if.up_down, a_if.load, a_if.hex_mode, a_if.load_val} = '0;
    {b_if.en, b_if.up_down, b_if.load, b_if.hex_mode, b_if.load_val} = '0;
    {c_if.en, c_if.up_down, c_if.load, c_if.hex_mode, c_if.load_val} = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_q", 64'(a_if.q), 0);
    chk("rst_tc", 64'(a_if.tc), 0);
    chk("rst_seg", 64'(a_if.seg), 64'({6{7'h7f}}));
    step(1);
    a_if.en = 1; a_if.up_down = 1;
    b_if.en = 1; b_if.up_down = 0;
    c_if.load = 1; c_if.load_val = 8'hB7; c_if.hex_mode = 1;
    rst = 1'b0;
    step(1);
    chk("b_wrap_q", 64'(b_if.q), 63);
    chk("b_wrap_tc", 64'(b_if.tc), 1);
    chk("c_load_q", 64'(c_if.q), 183);
    c_if.load = 0;
    step(1);
    chk("b_down_q", 64'(b_if.q), 62);
    chk("b_down_tc", 64'(b_if.tc), 0);
    chk("c_hex_seg", 64'(c_if.seg), 64'({{4{7'h7f}}, 7'b0000011, 7'b1111000}));
    step(2);
    chk("a_first_tick", 64'(a_if.q), 1);
    step(1);
    chk("a_bin_seg1", 64'(a_if.seg), 64'({{5{7'b1000000}}, 7'b1111001}));
    step(247);
    chk("a_q63", 64'(a_if.q), 63);
    step(4);
    chk("a_wrap_q", 64'(a_if.q), 0);
    chk("a_wrap_tc", 64'(a_if.tc), 1);
    step(1);
    chk("a_tc_drop", 64'(a_if.tc), 0);
    step(2);
    a_if.load = 1; a_if.load_val = 6'h2A;
    step(1);
    chk("a_load_prio", 64'(a_if.q), 42);
    a_if.load = 0;
    step(3);
    chk("a_load_hold", 64'(a_if.q), 42);
    step(1);
    chk("a_load_next", 64'(a_if.q), 43);
    a_if.load = 1; a_if.load_val = 0;
    step(1);
    a_if.load = 0; a_if.up_down = 0;
    step(4);
    chk("a_down_wrap_q", 64'(a_if.q), 63);
    chk("a_down_wrap_tc", 64'(a_if.tc), 1);
    a_if.en = 0; a_if.load = 1; a_if.load_val = 6'h0F;
    step(1);
    a_if.load = 0;
    step(1);
    chk("a_bin_0f", 64'(a_if.seg), 64'({{2{7'b1000000}}, {4{7'b1111001}}}));
    a_if.hex_mode = 1;
    step(1);
    chk("a_hex_0f", 64'(a_if.seg), 64'({{4{7'h7f}}, 7'b1000000, 7'b0001110}));
    a_if.hex_mode = 0; a_if.load = 1; a_if.load_val = 6'd37;
    step(1);
    a_if.load = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_q", 64'(a_if.q), 0);
    chk("async_tc", 64'(a_if.tc), 0);
    chk("async_seg", 64'(a_if.seg), 64'({6{7'h7f}}));
    #3 rst = 1'b0;
    step(80);
    chk("a_en0_hold", 64'(a_if.q), 0);
    a_if.en = 1; a_if.up_down = 1;
    step(3);
    chk("a_pre_tick", 64'(a_if.q), 0);
    step(1);
    chk("a_post_tick", 64'(a_if.q), 1);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
